// File: rtl/benes_ctrl_loader_if.sv
// rtl/benes_ctrl_loader_if.sv - control-word stream bundle for the Benes control loader
interface benes_ctrl_loader_if #(
  parameter int SWITCH_NUM = 16
) ();
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [SWITCH_NUM-1:0] cfg_data;
  logic                  cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/benes_ctrl_loader.sv
// rtl/benes_ctrl_loader.sv - double-buffered Benes switch-control loader; BENES_CTRL_IDENTITY_INIT_EN marks the reset bank valid
module benes_ctrl_loader #(
  parameter  int SIZE       = 32,
  localparam int SWITCH_NUM = SIZE / 2,
  localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1
) (
  input  logic                             clk,
  input  logic                             rst,
  benes_ctrl_loader_if.slave               cfg,
  input  logic                             net_swap_ok,
  output logic [STAGE_NUM*SWITCH_NUM-1:0]  ctrl_bits,
  output logic                             ctrl_valid,
  output logic                             cfg_err
);

  localparam int              TOTAL      = STAGE_NUM * SWITCH_NUM;
  localparam int              CNT_W      = $clog2(STAGE_NUM);
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(STAGE_NUM - 1);

`ifdef BENES_CTRL_IDENTITY_INIT_EN
  localparam logic INIT_VALID = 1'b1;
`else
  localparam logic INIT_VALID = 1'b0;
`endif

  typedef enum logic {
    LOAD = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stage_cnt_q, stage_cnt_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] active_q, active_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic accept;
  logic at_last;

  assign accept  = cfg.cfg_valid && cfg_ready_q;
  assign at_last = (stage_cnt_q == LAST_STAGE);

  always_comb begin
    state_d      = state_q;
    stage_cnt_d  = stage_cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    ctrl_valid_d = ctrl_valid_q;
    cfg_err_d    = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          shadow_d[stage_cnt_q*SWITCH_NUM +: SWITCH_NUM] = cfg.cfg_data;
          // cfg_last must coincide exactly with the final stage; anything else restarts framing
          if (cfg.cfg_last != at_last) begin
            cfg_err_d   = 1'b1;
            stage_cnt_d = '0;
          end else if (at_last) begin
            stage_cnt_d = '0;
            state_d     = PEND;
          end else begin
            stage_cnt_d = stage_cnt_q + CNT_W'(1);
          end
        end
      end
      PEND: begin
        if (net_swap_ok) begin
          active_d     = shadow_q;
          ctrl_valid_d = 1'b1;
          state_d      = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    cfg_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      stage_cnt_q  <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      ctrl_valid_q <= INIT_VALID;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_cnt_q  <= stage_cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      ctrl_valid_q <= ctrl_valid_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign ctrl_bits     = active_q;
  assign ctrl_valid    = ctrl_valid_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_benes_ctrl_loader.sv
// tb/tb_benes_ctrl_loader.sv - scoreboard bench for benes_ctrl_loader
module tb_benes_ctrl_loader;
  localparam int SIZE = 32;
  localparam int SW   = 16;
  localparam int ST   = 9;
  localparam int TOT  = SW * ST;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           net_swap_ok = 1'b0;
  logic [TOT-1:0] ctrl_bits;
  logic           ctrl_valid;
  logic           cfg_err;

  benes_ctrl_loader_if #(.SWITCH_NUM(SW)) cfg_if ();

  benes_ctrl_loader #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg_if),
    .net_swap_ok(net_swap_ok),
    .ctrl_bits  (ctrl_bits),
    .ctrl_valid (ctrl_valid),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             is_err;
    logic [TOT-1:0] bits;
  } ev_t;

  ev_t            exp_q[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [TOT-1:0] exp_bits = '0;
`ifdef BENES_CTRL_IDENTITY_INIT_EN
  logic           exp_rst_valid = 1'b1;
`else
  logic           exp_rst_valid = 1'b0;
`endif
  bit             mon_en = 1'b0;
  logic           rst_at_edge = 1'b1;
  logic [TOT-1:0] prev_bits = '0;
  logic           prev_valid = 1'b0;

  task automatic check(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [TOT-1:0] build(input logic [15:0] base);
    logic [TOT-1:0] r;
    r = '0;
    for (int s = 0; s < ST; s++) r[s*SW +: SW] = base + 16'(s);
    return r;
  endfunction

  // Monitor: every commit or cfg_err pulse must match the head of the queue
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    ev_t e;
    if (mon_en && !rst_at_edge) begin
      if (cfg_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_err: got cfg_err=1 expected no event");
        end else begin
          e = exp_q.pop_front();
          check1("event_is_err", 1'b1, e.is_err);
          check("err_bits_kept", ctrl_bits, e.bits);
        end
      end else if (ctrl_bits !== prev_bits || (ctrl_valid === 1'b1 && prev_valid !== 1'b1)) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_commit: got bits=%h expected no change", ctrl_bits);
        end else begin
          e = exp_q.pop_front();
          check1("event_is_commit", 1'b0, e.is_err);
          check("commit_bits", ctrl_bits, e.bits);
          check1("commit_valid", ctrl_valid, 1'b1);
        end
      end
    end
    prev_bits  = ctrl_bits;
    prev_valid = ctrl_valid;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    @(negedge clk);
    check1("rst_ready", cfg_if.cfg_ready, 1'b0);
    check("rst_bits", ctrl_bits, '0);
    check1("rst_valid", ctrl_valid, exp_rst_valid);
    check1("rst_err", cfg_err, 1'b0);
    rst = 1'b0;
    exp_bits = '0;
    @(negedge clk);
    check1("post_rst_ready", cfg_if.cfg_ready, 1'b1);
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    cfg_if.cfg_last  = l;
    n = 0;
    while (cfg_if.cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got cfg_ready=0 expected 1 within 50 cycles");
    end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
  endtask

  task automatic load(input logic [15:0] base, input bit push_commit);
    for (int s = 0; s < ST; s++) begin
      if (s == ST - 1 && push_commit) exp_q.push_back('{is_err: 1'b0, bits: build(base)});
      send(base + 16'(s), s == ST - 1);
    end
  endtask

  task automatic finish_commit(input logic [15:0] base);
    check1("pend_ready_low", cfg_if.cfg_ready, 1'b0);
    @(negedge clk);
    check1("commit_ready_back", cfg_if.cfg_ready, 1'b1);
    check("commit_bits_direct", ctrl_bits, build(base));
    exp_bits = build(base);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    cfg_if.cfg_last  = 1'b0;

    do_reset();
    mon_en = 1'b1;

    // Basic load with net_swap_ok held high
    net_swap_ok = 1'b1;
    load(16'h0001, 1'b1);
    check1("t1_valid_not_yet", ctrl_valid, exp_rst_valid);
    finish_commit(16'h0001);
    check1("t1_valid", ctrl_valid, 1'b1);

    // Commit held off by net_swap_ok
    net_swap_ok = 1'b0;
    load(16'h0100, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check1("t2_ready_low", cfg_if.cfg_ready, 1'b0);
      check("t2_bits_held", ctrl_bits, exp_bits);
      @(negedge clk);
    end
    net_swap_ok = 1'b1;
    @(negedge clk);
    check("t2_bits_commit", ctrl_bits, build(16'h0100));
    check1("t2_ready_back", cfg_if.cfg_ready, 1'b1);
    exp_bits = build(16'h0100);

    // Early cfg_last on 4th word
    for (int s = 0; s < 3; s++) send(16'hA000 + 16'(s), 1'b0);
    exp_q.push_back('{is_err: 1'b1, bits: exp_bits});
    send(16'hBEEF, 1'b1);
    check1("t3_err_high", cfg_err, 1'b1);
    check1("t3_ready", cfg_if.cfg_ready, 1'b1);
    @(negedge clk);
    check1("t3_err_low", cfg_err, 1'b0);
    load(16'h0200, 1'b1);
    finish_commit(16'h0200);

    // Missing cfg_last on 9th word
    exp_q.push_back('{is_err: 1'b1, bits: exp_bits});
    for (int s = 0; s < ST; s++) send(16'h0300 + 16'(s), 1'b0);
    check1("t4_err_high", cfg_err, 1'b1);
    check1("t4_no_pend", cfg_if.cfg_ready, 1'b1);
    @(negedge clk);
    check("t4_bits_kept", ctrl_bits, exp_bits);
    load(16'h0400, 1'b1);
    finish_commit(16'h0400);

    // Reset mid-load
    for (int s = 0; s < 5; s++) send(16'h0500 + 16'(s), 1'b0);
    do_reset();
    load(16'h0600, 1'b1);
    finish_commit(16'h0600);

    // Reset while pending
    net_swap_ok = 1'b0;
    load(16'h0700, 1'b0);
    check1("t6_pend", cfg_if.cfg_ready, 1'b0);
    do_reset();
    net_swap_ok = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_bits_zero", ctrl_bits, '0);
    check1("t6_valid", ctrl_valid, exp_rst_valid);
    load(16'h0800, 1'b1);
    finish_commit(16'h0800);

    repeat (5) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: got %0d pending events expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
